// File: rtl/jpegls_pkg.sv
// ============================================================================
// Package     : jpegls_pkg
// Description : Shared JPEG-LS widths, mode codes and pixel type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jpegls_pkg;

    localparam int PIXEL_LENGTH = 8;
    localparam int MODE_LENGTH  = 2;

    typedef logic [PIXEL_LENGTH-1:0] pixel_t;
    typedef logic [MODE_LENGTH-1:0]  mode_t;

    localparam mode_t MODE_REGULAR       = 2'b00;
    localparam mode_t MODE_RUN           = 2'b01;
    localparam mode_t MODE_RUN_INTERRUPT = 2'b10;

endpackage

`default_nettype wire

// File: rtl/predictor_if.sv
// ============================================================================
// Interface   : predictor_if
// Description : Sample-in / prediction-out bundle of the JPEG-LS predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface predictor_if;
    import jpegls_pkg::*;

    logic   in_valid;
    pixel_t a;
    pixel_t b;
    pixel_t c;
    mode_t  mode;
    logic   RIType;
    pixel_t x_prediction;
    logic   out_valid;

    modport master (
        output in_valid, a, b, c, mode, RIType,
        input  x_prediction, out_valid
    );

    modport slave (
        input  in_valid, a, b, c, mode, RIType,
        output x_prediction, out_valid
    );

endinterface

`default_nettype wire

// File: rtl/predictor_med_core.sv
// ============================================================================
// Module      : med_core
// Description : Combinational median edge detector (MED) predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module med_core
    import jpegls_pkg::*;
(
    input  wire pixel_t a,
    input  wire pixel_t b,
    input  wire pixel_t c,
    output pixel_t      px_med
);

    pixel_t                          w_mx;
    pixel_t                          w_mn;
    logic signed [PIXEL_LENGTH+1:0]  w_grad;

    assign w_mx = (a > b) ? a : b;
    assign w_mn = (a > b) ? b : a;

    // Only reached when mn < c < mx, so the result fits in a pixel.
    assign w_grad = $signed({2'b00, a}) + $signed({2'b00, b}) - $signed({2'b00, c});

    always_comb begin
        px_med = w_grad[PIXEL_LENGTH-1:0];
        if (c >= w_mx) begin
            px_med = w_mn;
        end else if (c <= w_mn) begin
            px_med = w_mx;
        end
    end

endmodule

`default_nettype wire

// File: rtl/predictor.sv
// ============================================================================
// Module      : predictor
// Description : JPEG-LS pixel predictor, one-cycle registered Px output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module predictor
    import jpegls_pkg::*;
(
    input  wire           clk,
    input  wire           rst,
    predictor_if.slave    bus
);

    pixel_t w_px_med;
    pixel_t px_d;
    pixel_t px_q;
    logic   valid_q;

    med_core u_med_core (
        .a      (bus.a),
        .b      (bus.b),
        .c      (bus.c),
        .px_med (w_px_med)
    );

    // Reserved mode code falls through to the regular MED path.
    always_comb begin
        px_d = w_px_med;
        case (bus.mode)
            MODE_RUN:           px_d = bus.a;
            MODE_RUN_INTERRUPT: px_d = bus.RIType ? bus.a : bus.b;
            default:            px_d = w_px_med;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                px_q <= px_d;
            end
        end
    end

    assign bus.x_prediction = px_q;
    assign bus.out_valid    = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_predictor.sv
// ============================================================================
// Module      : tb_predictor
// Description : Directed self-checking bench for the JPEG-LS predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_predictor;
    import jpegls_pkg::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    predictor_if bus ();

    predictor u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int a, input int b, input int c,
                         input mode_t m, input logic ri);
        bus.in_valid = v;
        bus.a        = pixel_t'(a);
        bus.b        = pixel_t'(b);
        bus.c        = pixel_t'(c);
        bus.mode     = m;
        bus.RIType   = ri;
    endtask

    // Drive one vector, clock it in, then check Px and out_valid just after the edge.
    task automatic step(input string tag, input int a, input int b, input int c,
                        input mode_t m, input logic ri, input int exp);
        @(negedge clk);
        drive(1'b1, a, b, c, m, ri);
        @(posedge clk);
        #1;
        check({tag, "_px"}, int'(bus.x_prediction), exp);
        check({tag, "_vld"}, int'(bus.out_valid), 1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        drive(1'b0, 0, 0, 0, MODE_REGULAR, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_px", int'(bus.x_prediction), 0);
        check("reset_vld", int'(bus.out_valid), 0);
        @(negedge clk);
        rst = 1'b0;

        // Regular mode, MED branches
        step("med_c_ge_mx", 100, 50, 120, MODE_REGULAR, 1'b0, 50);
        step("med_c_le_mn", 100, 50, 30,  MODE_REGULAR, 1'b1, 100);
        step("med_grad",    100, 50, 70,  MODE_REGULAR, 1'b0, 80);
        step("med_255",     255, 255, 0,  MODE_REGULAR, 1'b0, 255);
        step("med_0_255",   0, 255, 128,  MODE_REGULAR, 1'b0, 127);
        step("med_equal",   37, 37, 37,   MODE_REGULAR, 1'b0, 37);
        step("med_tie_mx",  200, 10, 200, MODE_REGULAR, 1'b0, 10);
        step("mode_rsvd",   100, 50, 70,  2'b11,        1'b0, 80);

        // Run and run-interruption selection
        step("run",         10, 20, 99, MODE_RUN,           1'b0, 10);
        step("ri_type1",    10, 20, 99, MODE_RUN_INTERRUPT, 1'b1, 10);
        step("ri_type0",    10, 20, 99, MODE_RUN_INTERRUPT, 1'b0, 20);

        // Back-to-back stream
        step("strm0", 10, 20, 5,  MODE_REGULAR,       1'b0, 20);
        step("strm1", 60, 40, 50, MODE_REGULAR,       1'b0, 50);
        step("strm2", 7, 9, 99,   MODE_RUN,           1'b0, 7);
        step("strm3", 3, 4, 0,    MODE_RUN_INTERRUPT, 1'b0, 4);

        // Idle gap holds the last prediction
        @(negedge clk);
        drive(1'b0, 250, 251, 252, MODE_RUN, 1'b1);
        @(posedge clk);
        #1;
        check("gap_vld", int'(bus.out_valid), 0);
        check("gap_px_hold", int'(bus.x_prediction), 4);

        // Asynchronous reset between edges while output is valid
        step("pre_rst", 100, 50, 70, MODE_REGULAR, 1'b0, 80);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_px", int'(bus.x_prediction), 0);
        check("async_rst_vld", int'(bus.out_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 0, 0, 0, MODE_REGULAR, 1'b0);
        @(posedge clk);
        #1;
        check("post_rst_idle_vld", int'(bus.out_valid), 0);
        step("post_rst", 200, 10, 200, MODE_REGULAR, 1'b0, 10);

        @(negedge clk);
        drive(1'b0, 0, 0, 0, MODE_REGULAR, 1'b0);
        @(posedge clk);
        #1;
        check("final_vld", int'(bus.out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
